// File: rtl/strobe_gen_pkg.sv
// Shared types and sizing helpers for the strobe generator.
package strobe_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } strobe_state_t;

  // Bits needed to hold values 0..v, never less than one.
  function automatic int bits_for(input int v);
    int w;
    w = $clog2(v + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/strobe_counter.sv
// Loadable down-counter; holds at zero instead of wrapping.
module strobe_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                       cnt_d = value_i;
    else if (en_i && (cnt_q != '0))   cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/strobe_gen.sv
// Fixed-width strobe generator with minimum low gap and a saturating request queue.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int HIGH_CYCLES_G = 1_000_000,
  parameter int LOW_CYCLES_G  = 1_000_000,
  parameter int PEND_MAX_G    = 3,
  localparam int PW           = $clog2(PEND_MAX_G + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          trig_i,
  input  logic          cancel_i,
  output logic          strobe_o,
  output logic          busy_o,
  output logic [PW-1:0] pending_o,
  output logic          overflow_o
);

  localparam int CW = bits_for(max2(HIGH_CYCLES_G, LOW_CYCLES_G));
  localparam logic [CW-1:0] HIGH_V = CW'(HIGH_CYCLES_G - 1);
  localparam logic [CW-1:0] LOW_V  = CW'(LOW_CYCLES_G - 1);
  localparam logic [PW-1:0] PMAX   = PW'(PEND_MAX_G);

  strobe_state_t state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          ld, en, zero, queue;
  logic [CW-1:0] ld_val;

  strobe_counter #(.W(CW)) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (ld),
    .value_i (ld_val),
    .en_i    (en),
    .zero_o  (zero)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = HIGH_V;
    en      = 1'b0;
    queue   = 1'b0;
    if (cancel_i) begin
      state_d = IDLE;
      pend_d  = '0;
      ld      = 1'b1;
      ld_val  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_i) begin
            state_d = HIGH;
            ld      = 1'b1;
          end
        end
        HIGH: begin
          queue = trig_i;
          if (zero) begin
            state_d = LOW;
            ld      = 1'b1;
            ld_val  = LOW_V;
          end else begin
            en = 1'b1;
          end
        end
        LOW: begin
          if (zero) begin
            // A live request takes this slot ahead of the queue; queue depth is untouched.
            if (trig_i) begin
              state_d = HIGH;
              ld      = 1'b1;
            end else if (pend_q != '0) begin
              state_d = HIGH;
              ld      = 1'b1;
              pend_d  = pend_q - PW'(1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            en    = 1'b1;
            queue = trig_i;
          end
        end
        default: state_d = IDLE;
      endcase
      if (queue) begin
        if (pend_q == PMAX) ovf_d  = 1'b1;
        else                pend_d = pend_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign strobe_o   = (state_q == HIGH);
  assign busy_o     = (state_q != IDLE);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen with H=4, L=3, PEND_MAX=2.
module tb_strobe_gen;

  localparam int NC = 48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig, cancel;
  logic       strobe, busy, ovf;
  logic [1:0] pend;

  int n_cmp = 0;
  int n_bad = 0;

  strobe_gen #(
    .HIGH_CYCLES_G (4),
    .LOW_CYCLES_G  (3),
    .PEND_MAX_G    (2)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .trig_i     (trig),
    .cancel_i   (cancel),
    .strobe_o   (strobe),
    .busy_o     (busy),
    .pending_o  (pend),
    .overflow_o (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [NC-1:0] trig, canc;
    logic [NC-1:0] strb, busy, pnd0, pnd1, ovf;
  } vec_t;

  vec_t tv[6];

  function automatic logic [NC-1:0] mk(input int lo, input int hi);
    logic [NC-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [NC-1:0] got, input logic [NC-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    trig   = 1'b0;
    cancel = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Bit c of each mask is cycle c: the interval following edge c-1.
  task automatic run_vec(input vec_t v);
    logic [NC-1:0] g_s, g_b, g_p0, g_p1, g_o;
    g_s = '0; g_b = '0; g_p0 = '0; g_p1 = '0; g_o = '0;
    do_reset();
    for (int e = 0; e < NC - 1; e++) begin
      trig   = v.trig[e];
      cancel = v.canc[e];
      @(posedge clk);
      #1;
      g_s[e+1]  = strobe;
      g_b[e+1]  = busy;
      g_p0[e+1] = pend[0];
      g_p1[e+1] = pend[1];
      g_o[e+1]  = ovf;
    end
    trig   = 1'b0;
    cancel = 1'b0;
    chk({v.name, ".strobe"},  g_s,  v.strb);
    chk({v.name, ".busy"},    g_b,  v.busy);
    chk({v.name, ".pend0"},   g_p0, v.pnd0);
    chk({v.name, ".pend1"},   g_p1, v.pnd1);
    chk({v.name, ".ovf"},     g_o,  v.ovf);
  endtask

  initial begin
    logic [NC-1:0] acc;
    // single request
    tv[0] = '{"single", mk(10,10), '0, mk(11,14), mk(11,17), '0, '0, '0};
    // queued request serviced after the low gap
    tv[1] = '{"queued", mk(10,10) | mk(12,12), '0, mk(11,14) | mk(18,21), mk(11,24),
              mk(13,17), '0, '0};
    // saturation: third queued request dropped
    tv[2] = '{"satur", mk(10,13), '0, mk(11,14) | mk(18,21) | mk(25,28), mk(11,31),
              mk(12,12) | mk(18,24), mk(13,17), mk(14,14)};
    // request in the last LOW cycle served with no added gap
    tv[3] = '{"lastlow", mk(10,10) | mk(17,17), '0, mk(11,14) | mk(18,21), mk(11,24),
              '0, '0, '0};
    // cancel with a simultaneous trig, then a fresh request
    tv[4] = '{"cancel", mk(10,12) | mk(20,20), mk(12,12), mk(11,12) | mk(21,24),
              mk(11,12) | mk(21,27), mk(12,12), '0, '0};
    // cancel on the cycle that would overflow suppresses the flag
    tv[5] = '{"cancovf", mk(10,13), mk(13,13), mk(11,13), mk(11,13),
              mk(12,12), mk(13,13), '0};

    // reset held: trig toggling must not leave IDLE
    rst_n = 1'b0; trig = 1'b0; cancel = 1'b0;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      trig = i[0];
      @(posedge clk);
      #1 acc[0] = acc[0] | strobe | busy | ovf | (pend != 2'd0);
    end
    chk("rst_hold", acc, '0);
    #1 rst_n = 1'b1;
    trig = 1'b0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 acc[0] = acc[0] | strobe | busy | ovf | (pend != 2'd0);
    end
    chk("rst_release", acc, '0);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // async reset mid-HIGH drops outputs before any clock edge
    do_reset();
    trig = 1'b1;
    @(posedge clk);
    #1 trig = 1'b1;
    @(posedge clk);
    #1 trig = 1'b0;
    chk("midhigh_strobe", NC'(strobe), NC'(1));
    chk("midhigh_pend",   NC'(pend),   NC'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_strobe", NC'(strobe), '0);
    chk("async_busy",   NC'(busy),   '0);
    chk("async_pend",   NC'(pend),   '0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_async_idle", NC'({strobe, busy}), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
